arb_mux_n: RTL

- Parametrised, registered N:1 datapath selector. Successor to the combinational 4:1 64-bit operand mux.
- Adds per-input valid/ready handshakes, a one-stage output register with backpressure, and a selectable arbitration mode: external select or round-robin.
- Sits between pipeline stages wherever several producers share one downstream consumer, e.g. writeback source select or a shared memory port.

---
 rtl/arb_mux_n.sv | 118 +++++++++++
 1 files changed

// File: rtl/arb_mux_n.sv
// Registered N:1 selector with per-input valid/ready, one output stage and
// external-select or round-robin arbitration. Optional counters: ARB_MUX_STATS_EN.
module arb_mux_n #(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned NUM_IN = 4,
  parameter int unsigned SEL_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel_ext,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_src,
  output logic                    out_valid,
  input  logic                    out_ready
`ifdef ARB_MUX_STATS_EN
  ,
  input  logic [SEL_W-1:0]        stat_idx,
  input  logic                    stat_clr,
  output logic [31:0]             stat_cnt
`endif
);

  if (SEL_W != $clog2(NUM_IN) || NUM_IN < 2 || NUM_IN > 16 ||
      (NUM_IN & (NUM_IN - 1)) != 0) begin : g_bad_params
    $error("arb_mux_n: NUM_IN must be a power of two in 2..16 and SEL_W = log2(NUM_IN)");
  end

  logic [WIDTH-1:0] ch [NUM_IN];
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] gnt;
  logic [SEL_W-1:0] rr_idx;
  logic             gnt_v;
  logic             load_ok;
  logic             xfer;

  for (genvar i = 0; i < NUM_IN; i++) begin : g_unpack
    assign ch[i] = in_data[i*WIDTH +: WIDTH];
  end

  assign load_ok = !flush && (!out_valid || out_ready);
  assign xfer    = load_ok && gnt_v;

  // Round-robin scans ptr+1 .. ptr+NUM_IN; descending loop lets the nearest requester win.
  always_comb begin
    gnt    = '0;
    gnt_v  = 1'b0;
    rr_idx = '0;
    if (mode) begin
      for (int k = NUM_IN; k >= 1; k--) begin
        rr_idx = ptr + SEL_W'(k);
        if (in_valid[rr_idx]) begin
          gnt   = rr_idx;
          gnt_v = 1'b1;
        end
      end
    end else begin
      gnt   = sel_ext;
      gnt_v = in_valid[sel_ext];
    end
  end

  // rst_n gating keeps every in_ready low while reset is held.
  always_comb begin
    in_ready = '0;
    if (rst_n && xfer) begin
      in_ready[gnt] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      ptr       <= SEL_W'(NUM_IN - 1);
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= ch[gnt];
      out_src   <= gnt;
      if (mode) begin
        ptr <= gnt;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef ARB_MUX_STATS_EN
  logic [31:0] cnt [NUM_IN];

  // Per-channel saturating grant counters; clear beats a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_IN; i++) begin
        cnt[i] <= '0;
      end
      stat_cnt <= '0;
    end else begin
      if (stat_clr) begin
        for (int i = 0; i < NUM_IN; i++) begin
          cnt[i] <= '0;
        end
      end else if (xfer && cnt[gnt] != 32'hFFFF_FFFF) begin
        cnt[gnt] <= cnt[gnt] + 32'd1;
      end
      stat_cnt <= cnt[stat_idx];
    end
  end
`endif

endmodule
